seq_divider: RTL and testbench

SEQ_DIVIDER -- requirements
Module: seq_divider

---
 rtl/seq_divider_if.sv | 44 ++++
 rtl/seq_divider.sv | 140 ++++++++++++++
 tb/tb_seq_divider.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/seq_divider_if.sv
// seq_divider_if -- handshake and data bundle for seq_divider.
//   start     : request a division with the current dividend/divisor
//   dividend  : unsigned numerator, WIDTH bits
//   divisor   : unsigned denominator, WIDTH bits
//   busy      : high while the divider is iterating
//   done      : high while quotient/remainder hold a valid result
//   quotient  : floor(dividend/divisor), WIDTH bits
//   remainder : dividend mod divisor, WIDTH bits
//   dbz       : divide-by-zero flag (only when DIVIDER_DBZ_EN is defined)
// master drives the request, slave is the divider.
interface seq_divider_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
`ifdef DIVIDER_DBZ_EN
  logic             dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, dbz
  );
`else
  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder
  );
`endif
endinterface

// File: rtl/seq_divider.sv
// seq_divider -- sequential restoring divider, one quotient bit per clock.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : seq_divider_if.slave (start/dividend/divisor in,
//           busy/done/quotient/remainder[/dbz] out)
// Parameter WIDTH (2..16): operand width in bits.
// Optional feature macro DIVIDER_DBZ_EN: adds the dbz flag and a one-cycle
// shortcut for a zero divisor. Without it a zero divisor runs the normal
// WIDTH-cycle algorithm, yielding quotient all ones and remainder = dividend.
module seq_divider #(
  parameter int WIDTH = 4
) (
  input logic          clk,
  input logic          rst_n,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  // dvd_q shifts dividend bits out of its MSB and quotient bits into its LSB,
  // so after WIDTH iterations it holds the full quotient.
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
`ifdef DIVIDER_DBZ_EN
  logic             dbz_q, dbz_d;
`endif

  logic [WIDTH:0]   shifted;
  logic             take;
  logic [WIDTH-1:0] rem_next;

  always_comb begin
    // One restoring step. The true difference is always below 2^WIDTH (the
    // partial remainder stays below the divisor, or equals the dividend
    // prefix when the divisor is zero), so a WIDTH-bit subtract is exact.
    shifted  = {rem_q, dvd_q[WIDTH-1]};
    take     = (shifted >= {1'b0, dvs_q});
    rem_next = take ? (shifted[WIDTH-1:0] - dvs_q) : shifted[WIDTH-1:0];

    state_d     = state_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIVIDER_DBZ_EN
    dbz_d       = dbz_q;
`endif

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          dvd_d   = bus.dividend;
          dvs_d   = bus.divisor;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = RUN;
`ifdef DIVIDER_DBZ_EN
          if (bus.divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = bus.dividend;
            dbz_d       = 1'b1;
          end else begin
            dbz_d       = 1'b0;
          end
`endif
        end
      end
      RUN: begin
        rem_d = rem_next;
        dvd_d = {dvd_q[WIDTH-2:0], take};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d     = DONE;
          quotient_d  = {dvd_q[WIDTH-2:0], take};
          remainder_d = rem_next;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIVIDER_DBZ_EN
      dbz_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIVIDER_DBZ_EN
      dbz_q       <= dbz_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
`ifdef DIVIDER_DBZ_EN
  assign bus.dbz       = dbz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider -- self-checking bench for seq_divider (WIDTH=4).
// Directed vector table, hand-written multi-cycle sequences and random
// operands checked against plain-arithmetic expectations.
module tb_seq_divider;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic void ref_div(input int a, input int b, output int q, output int r);
    if (b == 0) begin
      q = (1 << W) - 1;
      r = a;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Start one division, scramble the operands afterwards, then wait (bounded)
  // for done and compare latency and result.
  task automatic run_div(input int a, input int b, input int eq, input int er, input string name);
    int cycles;
    int lat;
    lat = W;
`ifdef DIVIDER_DBZ_EN
    if (b == 0) lat = 0;
`endif
    bus.start    = 1'b1;
    bus.dividend = W'(a);
    bus.divisor  = W'(b);
    tick();
    bus.start    = 1'b0;
    bus.dividend = W'($urandom);
    bus.divisor  = W'($urandom);
    cycles = 0;
    while (!bus.done && cycles < 4 * W) begin
      chk({name, " busy"}, int'(bus.busy), 1);
      tick();
      cycles++;
    end
    chk({name, " latency"}, cycles, lat);
    chk({name, " done"}, int'(bus.done), 1);
    chk({name, " busy at done"}, int'(bus.busy), 0);
    chk({name, " quotient"}, int'(bus.quotient), eq);
    chk({name, " remainder"}, int'(bus.remainder), er);
`ifdef DIVIDER_DBZ_EN
    chk({name, " dbz"}, int'(bus.dbz), (b == 0) ? 1 : 0);
`endif
  endtask

  task automatic chk_reset_state(input string name);
    chk({name, " busy"}, int'(bus.busy), 0);
    chk({name, " done"}, int'(bus.done), 0);
    chk({name, " quotient"}, int'(bus.quotient), 0);
    chk({name, " remainder"}, int'(bus.remainder), 0);
`ifdef DIVIDER_DBZ_EN
    chk({name, " dbz"}, int'(bus.dbz), 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int q;
    int r;
    int va[4];
    int vb[4];

    vecs[0] = '{a: 13, b: 3,  q: 4,  r: 1};
    vecs[1] = '{a: 15, b: 1,  q: 15, r: 0};
    vecs[2] = '{a: 5,  b: 7,  q: 0,  r: 5};
    vecs[3] = '{a: 0,  b: 9,  q: 0,  r: 0};
    vecs[4] = '{a: 9,  b: 0,  q: 15, r: 9};
    vecs[5] = '{a: 15, b: 15, q: 1,  r: 0};
    vecs[6] = '{a: 1,  b: 15, q: 0,  r: 1};
    vecs[7] = '{a: 14, b: 4,  q: 3,  r: 2};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    tick();
    tick();
    chk_reset_state("reset");
    rst_n = 1'b1;
    tick();
    chk_reset_state("idle after reset");

    foreach (vecs[i]) begin
      run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, $sformatf("vec%0d", i));
    end

    // done and result hold in DONE while start stays low
    tick();
    tick();
    chk("hold done", int'(bus.done), 1);
    chk("hold quotient", int'(bus.quotient), 3);
    chk("hold remainder", int'(bus.remainder), 2);

    // start during RUN is ignored
    bus.start    = 1'b1;
    bus.dividend = W'(13);
    bus.divisor  = W'(3);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start    = 1'b1;
    bus.dividend = W'(8);
    bus.divisor  = W'(2);
    tick();
    bus.start = 1'b0;
    q = 3;
    while (!bus.done && q < 4 * W) begin
      tick();
      q++;
    end
    chk("ignored start latency", q, W);
    chk("ignored start quotient", int'(bus.quotient), 4);
    chk("ignored start remainder", int'(bus.remainder), 1);

    // reset in the middle of RUN aborts the division
    bus.start    = 1'b1;
    bus.dividend = W'(13);
    bus.divisor  = W'(3);
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_reset_state("mid-run reset");
    tick();
    tick();
    tick();
    chk_reset_state("after abort");
    run_div(8, 2, 4, 0, "after reset 8/2");

    // reset overrides start at the same edge
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.dividend = W'(8);
    bus.divisor  = W'(2);
    tick();
    bus.start = 1'b0;
    rst_n     = 1'b1;
    chk_reset_state("reset over start");

    // back-to-back divisions with start held high
    for (int i = 0; i < 4; i++) begin
      va[i] = $urandom_range(0, 15);
      vb[i] = $urandom_range(1, 15);
    end
    bus.start    = 1'b1;
    bus.dividend = W'(va[0]);
    bus.divisor  = W'(vb[0]);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("b2b%0d busy", i), int'(bus.busy), 1);
      chk($sformatf("b2b%0d done low", i), int'(bus.done), 0);
      if (i < 3) begin
        bus.dividend = W'(va[i + 1]);
        bus.divisor  = W'(vb[i + 1]);
      end
      for (int k = 1; k < W; k++) begin
        tick();
        chk($sformatf("b2b%0d run done low", i), int'(bus.done), 0);
      end
      tick();
      ref_div(va[i], vb[i], q, r);
      chk($sformatf("b2b%0d done", i), int'(bus.done), 1);
      chk($sformatf("b2b%0d quotient", i), int'(bus.quotient), q);
      chk($sformatf("b2b%0d remainder", i), int'(bus.remainder), r);
    end
    bus.start = 1'b0;
    tick();

    // random operands against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      int a;
      int b;
      a = $urandom_range(0, 15);
      b = $urandom_range(0, 15);
      ref_div(a, b, q, r);
      run_div(a, b, q, r, $sformatf("rand%0d %0d/%0d", i, a, b));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
